// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
//   lc3b_word       16-bit address/data word
//   lc3b_mem_wmask  2-bit byte write mask
//   lc3b_arb_state  arbiter FSM state encoding
//   lc3b_mem_req    request fields latched at grant time
// captureReq() packs a requester's fields into a lc3b_mem_req.
package mem_port_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SERVE_IF  = 2'd1,
    ARB_SERVE_MEM = 2'd2
  } lc3b_arb_state;

  typedef struct packed {
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
  } lc3b_mem_req;

  localparam lc3b_mem_req REQ_RESET = '0;

  function automatic lc3b_mem_req captureReq(input logic          write,
                                             input lc3b_mem_wmask wmask,
                                             input lc3b_word      address,
                                             input lc3b_word      wdata);
    lc3b_mem_req r;
    r.write   = write;
    r.wmask   = wmask;
    r.address = address;
    r.wdata   = wdata;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used for the arbiter's performance counters.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears the count
//   inc    increment request for this cycle
//   count  current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count up on inc, but stop at all-ones so the value never wraps to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter that merges the pipeline's instruction-fetch (IF) and data (MEM)
// memory ports onto one shared physical memory port using the lc3b
// read/write/resp handshake.
//   clk, reset                     clock and asynchronous active-high reset
//   if_*  (read/write/wmask/...)   fetch requester; if_resp/if_rdata back
//   mem_* (read/write/wmask/...)   data requester; mem_resp/mem_rdata back
//   pmem_*                         shared port strobes, fields and response
//   if_grant_count, mem_grant_count  completed transactions per requester
//   stall_count                    cycles a requester waited on the other
// One requester is granted at a time; its request fields are latched at grant
// so the shared port stays stable until pmem_resp ends the transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 if_read,
  input  logic                 if_write,
  input  lc3b_mem_wmask        if_wmask,
  input  lc3b_word             if_address,
  input  lc3b_word             if_wdata,
  output logic                 if_resp,
  output lc3b_word             if_rdata,

  input  logic                 mem_read,
  input  logic                 mem_write,
  input  lc3b_mem_wmask        mem_wmask,
  input  lc3b_word             mem_address,
  input  lc3b_word             mem_wdata,
  output logic                 mem_resp,
  output lc3b_word             mem_rdata,

  output logic                 pmem_read,
  output logic                 pmem_write,
  output lc3b_mem_wmask        pmem_wmask,
  output lc3b_word             pmem_address,
  output lc3b_word             pmem_wdata,
  input  logic                 pmem_resp,
  input  lc3b_word             pmem_rdata,

  output logic [CNT_WIDTH-1:0] if_grant_count,
  output logic [CNT_WIDTH-1:0] mem_grant_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  lc3b_arb_state state_q, state_d;
  lc3b_mem_req   req_q, req_d;
  // Round-robin pointer: 1 means MEM wins the next conflict.
  logic          rrMem_q, rrMem_d;

  logic ifRequesting;
  logic memRequesting;
  logic pickMem;
  logic serving;
  logic stallInc;

  assign ifRequesting  = if_read | if_write;
  assign memRequesting = mem_read | mem_write;

  // Next-state and grant logic. Only IDLE may start a transaction; a serve
  // state leaves only on pmem_resp, so transactions are never aborted by the
  // requester dropping its strobe.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rrMem_d = rrMem_q;
    pickMem = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (ifRequesting && memRequesting) begin
          if (D_PRIORITY) begin
            pickMem = 1'b1;
          end else begin
            pickMem = rrMem_q;
            rrMem_d = ~rrMem_q;
          end
        end else begin
          pickMem = memRequesting;
        end
        if (ifRequesting || memRequesting) begin
          if (pickMem) begin
            req_d   = captureReq(mem_write, mem_wmask, mem_address, mem_wdata);
            state_d = ARB_SERVE_MEM;
          end else begin
            req_d   = captureReq(if_write, if_wmask, if_address, if_wdata);
            state_d = ARB_SERVE_IF;
          end
        end
      end
      ARB_SERVE_IF, ARB_SERVE_MEM: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, latched request and round-robin pointer. Reset parks the pointer
  // on MEM so the first conflict after reset goes to the data port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      req_q   <= REQ_RESET;
      rrMem_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rrMem_q <= rrMem_d;
    end
  end

  // Shared port is driven purely from the latched request; a latched write
  // takes precedence over read when a requester raised both.
  assign serving      = (state_q == ARB_SERVE_IF) || (state_q == ARB_SERVE_MEM);
  assign pmem_read    = serving & ~req_q.write;
  assign pmem_write   = serving & req_q.write;
  assign pmem_wmask   = req_q.wmask;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = req_q.wdata;

  // Responses are steered to the granted requester only; read data is forced
  // to zero outside the response cycle so X never leaks into IR/MDR.
  assign if_resp   = (state_q == ARB_SERVE_IF) & pmem_resp;
  assign mem_resp  = (state_q == ARB_SERVE_MEM) & pmem_resp;
  assign if_rdata  = if_resp  ? pmem_rdata : '0;
  assign mem_rdata = mem_resp ? pmem_rdata : '0;

  assign stallInc = ((state_q == ARB_SERVE_IF)  && memRequesting) ||
                    ((state_q == ARB_SERVE_MEM) && ifRequesting);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_ifGrantCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_resp),
    .count (if_grant_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_memGrantCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_resp),
    .count (mem_grant_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallInc),
    .count (stall_count)
  );

  // Protocol checks: a stray pmem_resp is ignored by the FSM but reported,
  // as is a requester raising read and write together.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(pmem_resp && (state_q == ARB_IDLE)))
        else $warning("mem_port_arbiter: pmem_resp outside a serve state ignored");
      assert (!(if_read && if_write))
        else $warning("mem_port_arbiter: IF port raised read and write together");
      assert (!(mem_read && mem_write))
        else $warning("mem_port_arbiter: MEM port raised read and write together");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Two instances share the request
// inputs and the shared-port response: dut uses the default parameters
// (16-bit counters, MEM priority) and dutRr uses 4-bit counters with
// round-robin conflict resolution.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        ifRead, ifWrite, memRead, memWrite;
  logic [1:0]  ifWmask, memWmask;
  logic [15:0] ifAddress, ifWdata, memAddress, memWdata;
  logic        pmemResp;
  logic [15:0] pmemRdata;

  logic        ifResp, memResp, pmemRead, pmemWrite;
  logic [15:0] ifRdata, memRdata, pmemAddress, pmemWdata;
  logic [1:0]  pmemWmask;
  logic [15:0] ifGrantCount, memGrantCount, stallCount;

  logic        rrIfResp, rrMemResp, rrPmemRead, rrPmemWrite;
  logic [15:0] rrIfRdata, rrMemRdata, rrPmemAddress, rrPmemWdata;
  logic [1:0]  rrPmemWmask;
  logic [3:0]  rrIfGrantCount, rrMemGrantCount, rrStallCount;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk (clk), .reset (reset),
    .if_read (ifRead), .if_write (ifWrite), .if_wmask (ifWmask),
    .if_address (ifAddress), .if_wdata (ifWdata),
    .if_resp (ifResp), .if_rdata (ifRdata),
    .mem_read (memRead), .mem_write (memWrite), .mem_wmask (memWmask),
    .mem_address (memAddress), .mem_wdata (memWdata),
    .mem_resp (memResp), .mem_rdata (memRdata),
    .pmem_read (pmemRead), .pmem_write (pmemWrite), .pmem_wmask (pmemWmask),
    .pmem_address (pmemAddress), .pmem_wdata (pmemWdata),
    .pmem_resp (pmemResp), .pmem_rdata (pmemRdata),
    .if_grant_count (ifGrantCount), .mem_grant_count (memGrantCount),
    .stall_count (stallCount)
  );

  mem_port_arbiter #(.CNT_WIDTH(4), .D_PRIORITY(1'b0)) dutRr (
    .clk (clk), .reset (reset),
    .if_read (ifRead), .if_write (ifWrite), .if_wmask (ifWmask),
    .if_address (ifAddress), .if_wdata (ifWdata),
    .if_resp (rrIfResp), .if_rdata (rrIfRdata),
    .mem_read (memRead), .mem_write (memWrite), .mem_wmask (memWmask),
    .mem_address (memAddress), .mem_wdata (memWdata),
    .mem_resp (rrMemResp), .mem_rdata (rrMemRdata),
    .pmem_read (rrPmemRead), .pmem_write (rrPmemWrite), .pmem_wmask (rrPmemWmask),
    .pmem_address (rrPmemAddress), .pmem_wdata (rrPmemWdata),
    .pmem_resp (pmemResp), .pmem_rdata (pmemRdata),
    .if_grant_count (rrIfGrantCount), .mem_grant_count (rrMemGrantCount),
    .stall_count (rrStallCount)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive both requesters' fields and let combinational outputs settle.
  task automatic applyStimulus(input logic ifRd, input logic ifWr,
                               input logic [1:0] ifMask, input logic [15:0] ifAddr,
                               input logic [15:0] ifData,
                               input logic memRd, input logic memWr,
                               input logic [1:0] memMask, input logic [15:0] memAddr,
                               input logic [15:0] memData);
    ifRead     = ifRd;
    ifWrite    = ifWr;
    ifWmask    = ifMask;
    ifAddress  = ifAddr;
    ifWdata    = ifData;
    memRead    = memRd;
    memWrite   = memWr;
    memWmask   = memMask;
    memAddress = memAddr;
    memWdata   = memData;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulseReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    pmemResp = 1'b0;
    pmemRdata = 16'h0000;
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);

    // Reset state
    #1;
    checkOutput("rst_pmem_read", pmemRead, 1'b0);
    checkOutput("rst_pmem_write", pmemWrite, 1'b0);
    checkOutput("rst_pmem_address", pmemAddress, 16'h0000);
    checkOutput("rst_if_resp", ifResp, 1'b0);
    checkOutput("rst_mem_resp", memResp, 1'b0);
    checkOutput("rst_if_cnt", ifGrantCount, 16'd0);
    checkOutput("rst_stall_cnt", stallCount, 16'd0);
    step();
    reset = 1'b0;

    // IF-only read, response on the third serve cycle
    applyStimulus(1, 0, 2'b11, 16'h1000, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    checkOutput("idle_no_strobe", pmemRead, 1'b0);
    step();
    checkOutput("if_pmem_read", pmemRead, 1'b1);
    checkOutput("if_pmem_address", pmemAddress, 16'h1000);
    checkOutput("if_rdata_zero_no_resp", ifRdata, 16'h0000);
    step();
    checkOutput("if_pmem_read_c2", pmemRead, 1'b1);
    step();
    pmemRdata = 16'h1234;
    pmemResp  = 1'b1;
    #1;
    checkOutput("if_resp", ifResp, 1'b1);
    checkOutput("if_rdata", ifRdata, 16'h1234);
    checkOutput("if_mem_resp_low", memResp, 1'b0);
    step();
    pmemResp = 1'b0;
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    checkOutput("if_grant_cnt", ifGrantCount, 16'd1);
    checkOutput("if_back_idle", pmemRead, 1'b0);

    // Simultaneous IF read and MEM write: MEM first under priority
    pulseReset();
    applyStimulus(1, 0, 2'b11, 16'h2000, 16'h0, 0, 1, 2'b01, 16'h3000, 16'hBEEF);
    step();
    checkOutput("pri_pmem_write", pmemWrite, 1'b1);
    checkOutput("pri_pmem_read", pmemRead, 1'b0);
    checkOutput("pri_pmem_address", pmemAddress, 16'h3000);
    checkOutput("pri_pmem_wdata", pmemWdata, 16'hBEEF);
    checkOutput("pri_pmem_wmask", pmemWmask, 2'b01);
    step();
    pmemRdata = 16'h7777;
    pmemResp  = 1'b1;
    #1;
    checkOutput("pri_mem_resp", memResp, 1'b1);
    checkOutput("pri_if_resp_low", ifResp, 1'b0);
    checkOutput("pri_if_rdata_zero", ifRdata, 16'h0000);
    step();
    pmemResp = 1'b0;
    applyStimulus(1, 0, 2'b11, 16'h2000, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    checkOutput("pri_stall_cnt", stallCount, 16'd2);
    checkOutput("pri_mem_cnt", memGrantCount, 16'd1);
    step();
    checkOutput("pri_if_pmem_read", pmemRead, 1'b1);
    checkOutput("pri_if_pmem_address", pmemAddress, 16'h2000);
    pmemRdata = 16'h5555;
    pmemResp  = 1'b1;
    #1;
    checkOutput("pri_if_resp", ifResp, 1'b1);
    checkOutput("pri_if_rdata", ifRdata, 16'h5555);
    checkOutput("pri_mem_rdata_zero", memRdata, 16'h0000);
    step();
    pmemResp = 1'b0;
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    checkOutput("pri_stall_final", stallCount, 16'd2);
    checkOutput("pri_if_cnt", ifGrantCount, 16'd1);

    // Requester changes its address mid-transaction
    pulseReset();
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 2'b11, 16'h4000, 16'h0);
    step();
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 2'b11, 16'h5000, 16'h0);
    checkOutput("hold_addr_c1", pmemAddress, 16'h4000);
    step();
    checkOutput("hold_addr_c2", pmemAddress, 16'h4000);
    pmemRdata = 16'hA5A5;
    pmemResp  = 1'b1;
    #1;
    checkOutput("hold_addr_resp", pmemAddress, 16'h4000);
    checkOutput("hold_mem_rdata", memRdata, 16'hA5A5);
    step();
    pmemResp = 1'b0;
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);

    // Reset during SERVE_MEM, then a stray pmem_resp in IDLE
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 1, 2'b10, 16'h6000, 16'h1111);
    step();
    checkOutput("rmid_pmem_write", pmemWrite, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rmid_pmem_write_fall", pmemWrite, 1'b0);
    checkOutput("rmid_mem_cnt", memGrantCount, 16'd0);
    checkOutput("rmid_if_cnt", ifGrantCount, 16'd0);
    checkOutput("rmid_stall_cnt", stallCount, 16'd0);
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    reset = 1'b0;
    pmemRdata = 16'hDEAD;
    pmemResp  = 1'b1;
    #1;
    checkOutput("stray_if_resp", ifResp, 1'b0);
    checkOutput("stray_mem_resp", memResp, 1'b0);
    checkOutput("stray_mem_rdata", memRdata, 16'h0000);
    step();
    checkOutput("stray_stay_idle", pmemRead | pmemWrite, 1'b0);
    checkOutput("stray_mem_cnt", memGrantCount, 16'd0);
    pmemResp = 1'b0;

    // Round-robin: both ports requesting for four transactions
    pulseReset();
    applyStimulus(1, 0, 2'b11, 16'h0100, 16'h0, 1, 0, 2'b11, 16'h0200, 16'h0);
    for (int t = 0; t < 4; t++) begin
      step();
      checkOutput($sformatf("rr_addr_%0d", t), rrPmemAddress,
                  (t % 2 == 0) ? 32'h0200 : 32'h0100);
      pmemResp = 1'b1;
      #1;
      checkOutput($sformatf("rr_mem_resp_%0d", t), rrMemResp, (t % 2 == 0) ? 1'b1 : 1'b0);
      checkOutput($sformatf("rr_if_resp_%0d", t), rrIfResp, (t % 2 == 1) ? 1'b1 : 1'b0);
      step();
      pmemResp = 1'b0;
    end
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    checkOutput("rr_if_cnt", rrIfGrantCount, 4'd2);
    checkOutput("rr_mem_cnt", rrMemGrantCount, 4'd2);
    checkOutput("rr_stall_cnt", rrStallCount, 4'd4);

    // 4-bit counter saturation over 17 IF transactions
    pulseReset();
    applyStimulus(1, 0, 2'b11, 16'h0800, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    for (int t = 0; t < 17; t++) begin
      step();
      pmemResp = 1'b1;
      step();
      pmemResp = 1'b0;
      if (t == 14) begin
        checkOutput("sat_at_15", rrIfGrantCount, 4'hF);
      end
    end
    applyStimulus(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
    checkOutput("sat_hold", rrIfGrantCount, 4'hF);
    checkOutput("sat_mem_cnt", rrMemGrantCount, 4'd0);
    checkOutput("sat_wide_if_cnt", ifGrantCount, 16'd17);
    checkOutput("sat_wide_stall", stallCount, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
